// File: rtl/counter_updn.sv
// Up/down counter with wrap or one-shot stop, load/clear and cascade outputs.
// Reset asserts asynchronously and is released through an internal sync flop.
module counter_updn #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               ONE_SHOT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] counter,
  output logic             co,
  output logic             bo,
  output logic             done
);

  logic             run_q;
  logic             run_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             done_q;
  logic             done_d;
  logic             at_max;
  logic             at_zero;
  logic             step;

  // Counter register forms the second release stage behind run_q.
  assign run_d   = 1'b1;
  assign at_max  = (cnt_q == MAX_VAL);
  assign at_zero = (cnt_q == '0);
  assign step    = run_q & en & ~clr & ~load & ~done_q;

  assign co      = step & up & at_max;
  assign bo      = step & ~up & at_zero;
  assign counter = cnt_q;
  assign done    = done_q;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (run_q) begin
      if (clr) begin
        cnt_d  = '0;
        done_d = 1'b0;
      end else if (load) begin
        cnt_d  = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        done_d = 1'b0;
      end else if (step) begin
        if (up) begin
          if (!at_max) begin
            cnt_d = cnt_q + 1'b1;
          end else if (ONE_SHOT) begin
            done_d = 1'b1;
          end else begin
            cnt_d = '0;
          end
        end else begin
          if (!at_zero) begin
            cnt_d = cnt_q - 1'b1;
          end else if (ONE_SHOT) begin
            done_d = 1'b1;
          end else begin
            cnt_d = MAX_VAL;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_counter_updn.sv
// Scoreboard bench for counter_updn: wrap, one-shot, priority,
// async reset release and a two-stage cascade.
module tb_counter_updn;

  typedef struct {
    string       tag;
    int          k;
    logic [31:0] cnt;
    logic        dn;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en_s [3];
  logic       up_s [3];
  logic       ld_s [3];
  logic       clr_s[3];
  logic [3:0] lv_s [3];

  logic [3:0] cnt0, cnt1, cnt2;
  logic       co0, co1, co2;
  logic       bo0, bo1, bo2;
  logic       done0, done1, done2;

  logic       c_en;
  logic       c_up;
  logic       c_zero;
  logic [3:0] c_lv;
  logic [3:0] lo_cnt, hi_cnt;
  logic       lo_co, lo_bo, lo_done;
  logic       hi_co, hi_bo, hi_done;

  exp_t sb[$];
  int   n_chk;
  int   n_fail;

  counter_updn #(.WIDTH(4), .MAX_VAL(15), .ONE_SHOT(0)) u_d0 (
    .clk(clk), .rst(rst), .en(en_s[0]), .up(up_s[0]),
    .load(ld_s[0]), .load_val(lv_s[0]), .clr(clr_s[0]),
    .counter(cnt0), .co(co0), .bo(bo0), .done(done0)
  );

  counter_updn #(.WIDTH(4), .MAX_VAL(9), .ONE_SHOT(0)) u_d1 (
    .clk(clk), .rst(rst), .en(en_s[1]), .up(up_s[1]),
    .load(ld_s[1]), .load_val(lv_s[1]), .clr(clr_s[1]),
    .counter(cnt1), .co(co1), .bo(bo1), .done(done1)
  );

  counter_updn #(.WIDTH(4), .MAX_VAL(5), .ONE_SHOT(1)) u_d2 (
    .clk(clk), .rst(rst), .en(en_s[2]), .up(up_s[2]),
    .load(ld_s[2]), .load_val(lv_s[2]), .clr(clr_s[2]),
    .counter(cnt2), .co(co2), .bo(bo2), .done(done2)
  );

  counter_updn #(.WIDTH(4)) u_lo (
    .clk(clk), .rst(rst), .en(c_en), .up(c_up),
    .load(c_zero), .load_val(c_lv), .clr(c_zero),
    .counter(lo_cnt), .co(lo_co), .bo(lo_bo), .done(lo_done)
  );

  counter_updn #(.WIDTH(4)) u_hi (
    .clk(clk), .rst(rst), .en(lo_co), .up(c_up),
    .load(c_zero), .load_val(c_lv), .clr(c_zero),
    .counter(hi_cnt), .co(hi_co), .bo(hi_bo), .done(hi_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int k);
    case (k)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      2:       return 32'(cnt2);
      default: return 32'({hi_cnt, lo_cnt});
    endcase
  endfunction

  function automatic logic done_of(input int k);
    case (k)
      0:       return done0;
      1:       return done1;
      2:       return done2;
      default: return lo_done | hi_done;
    endcase
  endfunction

  task automatic drv(input int k, input logic e, input logic u,
                     input logic l, input logic c, input logic [3:0] v);
    en_s[k]  = e;
    up_s[k]  = u;
    ld_s[k]  = l;
    clr_s[k] = c;
    lv_s[k]  = v;
  endtask

  task automatic exp_next(input string t, input int k, input int c,
                          input logic d);
    exp_t e;
    e.tag = t;
    e.k   = k;
    e.cnt = 32'(c);
    e.dn  = d;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_cnt"}, cnt_of(e.k), e.cnt);
      chk({e.tag, "_done"}, 32'(done_of(e.k)), 32'(e.dn));
    end
  end

  initial begin
    int   cur;
    int   comb;
    logic dn;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    c_en   = 1'b0;
    c_up   = 1'b1;
    c_zero = 1'b0;
    c_lv   = 4'd0;
    for (int k = 0; k < 3; k++) drv(k, 0, 0, 0, 0, 4'd0);
    drv(0, 1, 1, 1, 0, 4'd5);
    repeat (3) @(negedge clk);
    chk("rst_cnt0", 32'(cnt0), 0);
    chk("rst_co0", 32'(co0), 0);
    chk("rst_bo0", 32'(bo0), 0);
    chk("rst_done2", 32'(done2), 0);

    drv(0, 1, 1, 0, 0, 4'd0);
    rst = 1'b1;
    exp_next("rel_e1", 0, 0, 0);
    @(negedge clk);
    exp_next("rel_e2", 0, 1, 0);
    @(negedge clk);
    drv(0, 0, 1, 0, 1, 4'd0);
    exp_next("clr0", 0, 0, 0);

    cur = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drv(0, 1, 1, 0, 0, 4'd0);
      #1 chk("co_up", 32'(co0), 32'(cur == 15));
      cur = (cur + 1) % 16;
      exp_next("up17", 0, cur, 0);
    end

    @(negedge clk); drv(0, 1, 1, 1, 0, 4'd7);
    exp_next("ld_en", 0, 7, 0);
    @(negedge clk); drv(0, 1, 1, 1, 1, 4'd3);
    #1 chk("co_clr", 32'(co0), 0);
    exp_next("clr_ld_en", 0, 0, 0);
    @(negedge clk); drv(0, 0, 1, 1, 0, 4'd15);
    exp_next("ld15", 0, 15, 0);
    @(negedge clk); drv(0, 1, 1, 1, 0, 4'd15);
    #1 chk("co_ld", 32'(co0), 0);
    exp_next("ld_hold", 0, 15, 0);
    @(negedge clk); drv(0, 1, 1, 0, 0, 4'd0);
    #1 chk("co_max", 32'(co0), 1);
    exp_next("wrap", 0, 0, 0);
    @(negedge clk); drv(0, 1, 0, 0, 0, 4'd0);
    #1 chk("bo_zero", 32'(bo0), 1);
    exp_next("dn_wrap", 0, 15, 0);
    @(negedge clk); drv(0, 1, 1, 0, 0, 4'd0);
    #1 chk("bo_up", 32'(bo0), 0);
    exp_next("dir_chg", 0, 0, 0);
    @(negedge clk); drv(0, 0, 0, 0, 0, 4'd0);
    exp_next("hold", 0, 0, 0);

    @(negedge clk); drv(1, 1, 0, 0, 0, 4'd0);
    #1 chk("bo9", 32'(bo1), 1);
    exp_next("dn9", 1, 9, 0);
    @(negedge clk); drv(1, 0, 1, 1, 0, 4'd12);
    exp_next("ld12", 1, 9, 0);
    @(negedge clk); drv(1, 1, 1, 0, 0, 4'd0);
    #1 chk("co9", 32'(co1), 1);
    exp_next("wrap9", 1, 0, 0);
    @(negedge clk); drv(1, 0, 0, 0, 0, 4'd0);
    exp_next("hold9", 1, 0, 0);

    cur = 0;
    dn  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drv(2, 1, 1, 0, 0, 4'd0);
      #1 chk("os_co", 32'(co2), 32'(cur == 5));
      if (cur == 5) dn = 1'b1;
      else cur = cur + 1;
      exp_next("os_up", 2, cur, dn);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 chk("os_co_done", 32'(co2), 0);
      exp_next("os_stop", 2, 5, 1);
    end
    @(negedge clk); drv(2, 1, 0, 0, 0, 4'd0);
    #1 chk("os_bo_done", 32'(bo2), 0);
    exp_next("os_stop_dn", 2, 5, 1);
    @(negedge clk); drv(2, 0, 1, 1, 0, 4'd2);
    exp_next("os_ld", 2, 2, 0);
    @(negedge clk); drv(2, 1, 0, 0, 0, 4'd0);
    exp_next("os_dn1", 2, 1, 0);
    @(negedge clk);
    exp_next("os_dn0", 2, 0, 0);
    @(negedge clk);
    #1 chk("os_bo", 32'(bo2), 1);
    exp_next("os_dn_stop", 2, 0, 1);
    @(negedge clk); drv(2, 1, 0, 0, 1, 4'd0);
    exp_next("os_clr", 2, 0, 0);
    @(negedge clk); drv(2, 0, 0, 0, 0, 4'd0);
    exp_next("os_idle", 2, 0, 0);

    @(negedge clk); drv(0, 0, 1, 1, 0, 4'd10);
    exp_next("ld10", 0, 10, 0);
    @(negedge clk); drv(0, 1, 1, 0, 0, 4'd0);
    #2 rst = 1'b0;
    #1 chk("async_cnt", 32'(cnt0), 0);
    chk("async_co", 32'(co0), 0);
    @(negedge clk);
    rst = 1'b1;
    exp_next("rel2_e1", 0, 0, 0);
    @(negedge clk);
    exp_next("rel2_e2", 0, 1, 0);
    @(negedge clk); drv(0, 0, 1, 0, 0, 4'd0);
    exp_next("rel2_hold", 0, 1, 0);

    comb = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      c_en = 1'b1;
      #1 chk("casc_co", 32'(hi_co), 32'(comb == 255));
      comb = (comb + 1) % 256;
      exp_next("casc", 3, comb, 0);
    end
    @(negedge clk);
    c_en = 1'b0;
    chk("casc_hi_bo", 32'(hi_bo), 0);
    chk("casc_lo_bo", 32'(lo_bo), 0);
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_updn.md
COUNTER_UPDN -- requirements
Module: counter_updn

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits; legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, terminal value; legal range 1..2**WIDTH-1; count range is 0..MAX_VAL.
REQ-003 Parameter ONE_SHOT, default 0; 0 = wrap at terminal, 1 = stop at terminal.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  count enable.
REQ-007 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous load request.
REQ-009 load_val  input  WIDTH  value loaded on load.
REQ-010 clr  input  1  synchronous clear to 0.
REQ-011 counter  output  WIDTH  registered count value.
REQ-012 co  output  1  carry-out, combinational.
REQ-013 bo  output  1  borrow-out, combinational.
REQ-014 done  output  1  registered terminal flag, one-shot mode only.

Function
REQ-015 Per-edge priority SHALL be clr > load > (en and not stopped) > hold.
REQ-016 clr SHALL set counter to 0 and done to 0 on the next edge, regardless of the other inputs.
REQ-017 load SHALL set counter to min(load_val, MAX_VAL) and done to 0 on the next edge.
REQ-018 With en=1 and up=1, counter SHALL increment by 1 per edge; from MAX_VAL it SHALL go to 0 (ONE_SHOT=0).
REQ-019 With en=1 and up=0, counter SHALL decrement by 1 per edge; from 0 it SHALL go to MAX_VAL (ONE_SHOT=0).
REQ-020 With en=0 and no clr/load, counter and done SHALL hold.
REQ-021 co SHALL equal en & up & (counter==MAX_VAL) & ~clr & ~load, and is valid in the same cycle (zero latency) for cascading.
REQ-022 bo SHALL equal en & ~up & (counter==0) & ~clr & ~load.
REQ-023 Stop states (ONE_SHOT=1): "stopped" is done=1.
REQ-024 When ONE_SHOT=1 and an enabled step would wrap (up at MAX_VAL or down at 0), counter SHALL hold and done SHALL set to 1 on that edge.
REQ-025 While done=1, en SHALL have no effect; only clr, load or reset leave the stopped state.
REQ-026 When ONE_SHOT=0, done SHALL remain constant 0.
REQ-027 A direction change SHALL take effect on the same edge with no penalty cycle.
REQ-028 Arithmetic SHALL be modulo (MAX_VAL+1); counter SHALL never hold a value above MAX_VAL.
REQ-029 In ONE_SHOT=1, co and bo SHALL still assert on the terminal cycle, including the cycle in which done sets.
REQ-030 While done=1, co and bo SHALL be 0.

Reset
REQ-031 rst=0 SHALL immediately, without a clock, force counter=0 and done=0.
REQ-032 While rst=0, co=0 and bo=0 SHALL hold, and all inputs SHALL be ignored.
REQ-033 Reset deassertion SHALL be synchronised inside the block (two-flop release) so that the first count occurs no earlier than the second rising edge after rst rises.
REQ-034 Reset asserted mid-count or mid-load SHALL override, with no partial update visible.

Verification
REQ-035 WIDTH=4, MAX_VAL=15, ONE_SHOT=0: en=1, up=1 for 17 edges -> counter 1..15,0,1; co=1 only in the cycle with counter=15.
REQ-036 WIDTH=4, MAX_VAL=9, ONE_SHOT=0: up=0 from counter=0 -> next value 9, bo=1 at 0; load with load_val=12 -> counter=9.
REQ-037 ONE_SHOT=1, MAX_VAL=5: count up from 0 -> counter stops at 5 with done=1 after 6 enabled edges; further en has no effect; load with load_val=2 -> counter=2, done=0.
REQ-038 Simultaneous clr=1, load=1, en=1 at counter=7 -> counter=0; load=1 with en=1 -> counter=load_val, no increment.
REQ-039 rst pulsed low between clock edges with counter=0xA -> counter=0 immediately; after rst rises, counter stays 0 at the first edge and counts from the second edge.
REQ-040 Two instances cascaded, with the low co driving the high en (WIDTH=4 each): 256 edges -> combined {hi,lo} goes 0x00..0xFF,0x00; high co=1 only at 0xFF.
